// File: rtl/aes_shiftrows_pipe.sv
// Registered Rijndael ShiftRows / InvShiftRows stage for Nb = 4/6/8 with a skid buffer,
// synchronous flush and a count of delivered blocks.
module aes_shiftrows_pipe #(
  parameter int NB    = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              inv_i,
  input  logic [32*NB-1:0]  data_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [32*NB-1:0]  data_o,
  output logic [CNT_W-1:0]  blk_cnt_o
);

  localparam int W = 32 * NB;

  generate
    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
      $error("aes_shiftrows_pipe: NB must be 4, 6 or 8");
    end
  endgenerate

  // Row rotation amount C_r; the 256-bit block uses the wider 3/4 offsets on rows 2/3.
  function automatic int row_off(input int r);
    int off;
    case (r)
      0:       off = 0;
      1:       off = 1;
      2:       off = (NB == 8) ? 3 : 2;
      3:       off = (NB == 8) ? 4 : 3;
      default: off = 0;
    endcase
    return off;
  endfunction

  function automatic logic [W-1:0] permute(input logic [W-1:0] d, input logic inv);
    logic [W-1:0] p;
    int           src;
    p = {W{1'b0}};
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (inv) begin
          src = (c - row_off(r) + NB) % NB;
        end else begin
          src = (c + row_off(r)) % NB;
        end
        p[8*(4*NB-1-(r+4*c)) +: 8] = d[8*(4*NB-1-(r+4*src)) +: 8];
      end
    end
    return p;
  endfunction

  logic             out_valid_q, out_valid_d;
  logic [W-1:0]     data_q, data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [W-1:0]     skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [W-1:0]     perm_s;
  logic             accept_s;
  logic             drain_s;

  assign perm_s   = permute(data_i, inv_i);
  assign accept_s = in_valid & in_ready_q;
  assign drain_s  = out_valid_q & out_ready;

  // Next-state: refill the output register from skid first, then from the input.
  always_comb begin
    out_valid_d  = out_valid_q;
    data_d       = data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    cnt_d        = cnt_q;
    if (flush_i) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      cnt_d        = {CNT_W{1'b0}};
    end else begin
      if (drain_s) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_d = cnt_q;
      end
      if (!out_valid_q || drain_s) begin
        if (skid_valid_q) begin
          out_valid_d = 1'b1;
          data_d      = skid_data_q;
          if (accept_s) begin
            skid_valid_d = 1'b1;
            skid_data_d  = perm_s;
          end else begin
            skid_valid_d = 1'b0;
          end
        end else if (accept_s) begin
          out_valid_d = 1'b1;
          data_d      = perm_s;
        end else begin
          out_valid_d = 1'b0;
        end
      end else if (accept_s) begin
        skid_valid_d = 1'b1;
        skid_data_d  = perm_s;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  // State registers; in_ready is kept as its own flop so it never sees out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      data_q       <= {W{1'b0}};
      skid_valid_q <= 1'b0;
      skid_data_q  <= {W{1'b0}};
      in_ready_q   <= 1'b1;
      cnt_q        <= {CNT_W{1'b0}};
    end else begin
      out_valid_q  <= out_valid_d;
      data_q       <= data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_o    = data_q;
  assign blk_cnt_o = cnt_q;

endmodule

// File: tb/tb_aes_shiftrows_pipe.sv
// Bench for aes_shiftrows_pipe: NB=4/CNT_W=4 instance driven against a queue scoreboard,
// NB=8 instance driven at full rate for round-trip checks.
module tb_aes_shiftrows_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         a_flush = 1'b0, a_in_valid = 1'b0, a_inv = 1'b0, a_out_ready = 1'b0;
  logic [127:0] a_data_i = 128'd0;
  logic         a_in_ready, a_out_valid;
  logic [127:0] a_data_o;
  logic [3:0]   a_cnt;

  logic         b_flush = 1'b0, b_in_valid = 1'b0, b_inv = 1'b0, b_out_ready = 1'b1;
  logic [255:0] b_data_i = 256'd0;
  logic         b_in_ready, b_out_valid;
  logic [255:0] b_data_o;
  logic [15:0]  b_cnt;

  aes_shiftrows_pipe #(.NB(4), .CNT_W(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush_i(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .inv_i(a_inv), .data_i(a_data_i), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .data_o(a_data_o), .blk_cnt_o(a_cnt));

  aes_shiftrows_pipe #(.NB(8), .CNT_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush_i(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .inv_i(b_inv), .data_i(b_data_i), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .data_o(b_data_o), .blk_cnt_o(b_cnt));

  int passed = 0;
  int checks = 0;

  logic [127:0] sb_q[$];
  int           cnt_m = 0;
  int           drained = 0;
  bit           stall_m = 1'b0;
  logic [127:0] hold_m = 128'd0;

  // Reference: lay the block out as a 4 x nb byte matrix and rotate each row step by step.
  function automatic logic [255:0] ref_sr(input logic [255:0] d, input logic inv, input int nb);
    logic [7:0]   st[4][8];
    logic [7:0]   tmp;
    logic [255:0] res;
    int           sh;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < nb; cc++)
        st[rr][cc] = d[8*(4*nb-1-(rr+4*cc)) +: 8];
    for (int rr = 0; rr < 4; rr++) begin
      sh = (rr < 2) ? rr : ((nb == 8) ? rr + 1 : rr);
      for (int k = 0; k < sh; k++) begin
        if (!inv) begin
          tmp = st[rr][0];
          for (int cc = 0; cc < nb - 1; cc++) st[rr][cc] = st[rr][cc+1];
          st[rr][nb-1] = tmp;
        end else begin
          tmp = st[rr][nb-1];
          for (int cc = nb - 1; cc > 0; cc--) st[rr][cc] = st[rr][cc-1];
          st[rr][0] = tmp;
        end
      end
    end
    res = 256'd0;
    for (int rr = 0; rr < 4; rr++)
      for (int cc = 0; cc < nb; cc++)
        res[8*(4*nb-1-(rr+4*cc)) +: 8] = st[rr][cc];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One cycle on instance A: check state against the scoreboard, drive, account handshakes.
  task automatic step_a(input bit fl, input bit v, input bit inv, input logic [127:0] d,
                        input bit rdy, output bit acc);
    logic [255:0] t;
    bit drn;
    @(negedge clk);
    checks++;
    if (a_out_valid !== (sb_q.size() > 0)) $display("FAIL out_valid got=%b exp=%b", a_out_valid, sb_q.size() > 0);
    else passed++;
    checks++;
    if (a_in_ready !== (sb_q.size() < 2)) $display("FAIL in_ready got=%b exp=%b", a_in_ready, sb_q.size() < 2);
    else passed++;
    checks++;
    if (a_cnt !== cnt_m[3:0]) $display("FAIL blk_cnt got=%0d exp=%0d", a_cnt, cnt_m[3:0]);
    else passed++;
    if (stall_m) begin
      checks++;
      if (a_data_o !== hold_m) $display("FAIL stall_stable got=%h exp=%h", a_data_o, hold_m);
      else passed++;
    end
    a_flush = fl; a_in_valid = v; a_inv = inv; a_data_i = d; a_out_ready = rdy;
    acc = v && a_in_ready;
    drn = a_out_valid && rdy;
    stall_m = a_out_valid && !rdy && !fl;
    hold_m = a_data_o;
    if (fl) begin
      sb_q.delete();
      cnt_m = 0;
      acc = 1'b0;
    end else begin
      if (drn && sb_q.size() > 0) begin
        checks++;
        if (a_data_o !== sb_q[0]) $display("FAIL order_data got=%h exp=%h", a_data_o, sb_q[0]);
        else passed++;
        void'(sb_q.pop_front());
        cnt_m = (cnt_m + 1) % 16;
        drained++;
      end
      if (acc) begin
        t = ref_sr({128'd0, d}, inv, 4);
        sb_q.push_back(t[127:0]);
      end
    end
  endtask

  task automatic idle_a(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step_a(1'b0, 1'b0, 1'b0, 128'd0, 1'b1, acc);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_data_o !== 128'd0 || a_cnt !== 4'd0)
      $display("FAIL reset_a got=%b%b %h %0d exp=01 0 0", a_out_valid, a_in_ready, a_data_o, a_cnt);
    else passed++;
    checks++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_data_o !== 256'd0 || b_cnt !== 16'd0)
      $display("FAIL reset_b got=%b%b %h %0d exp=01 0 0", b_out_valid, b_in_ready, b_data_o, b_cnt);
    else passed++;
    rst_n = 1'b1;
  endtask

  task automatic test_fwd_vector();
    bit acc;
    step_a(1'b0, 1'b1, 1'b0, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1, acc);
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b1 || a_data_o !== 128'hd4bf5d30e0b452aeb84111f11e2798e5)
      $display("FAIL t1_fwd got=%b %h exp=1 d4bf5d30e0b452aeb84111f11e2798e5", a_out_valid, a_data_o);
    else passed++;
    idle_a(2);
  endtask

  task automatic test_inv_alternate();
    bit acc;
    step_a(1'b0, 1'b1, 1'b1, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, acc);
    @(posedge clk); #1;
    checks++;
    if (a_data_o !== 128'hd42711aee0bf98f1b8b45de51e415230)
      $display("FAIL t2_inv got=%h exp=d42711aee0bf98f1b8b45de51e415230", a_data_o);
    else passed++;
    for (int i = 0; i < 20; i++) step_a(1'b0, 1'b1, i[0], rand128(), 1'b1, acc);
    idle_a(2);
  endtask

  task automatic test_nb8();
    logic [255:0] x, expv, orig;
    int cm;
    for (int n = 0; n < 32; n++) x[8*(31-n) +: 8] = n[7:0];
    cm = 0;
    @(negedge clk);
    b_in_valid = 1'b1; b_inv = 1'b0; b_data_i = x;
    expv = ref_sr(x, 1'b0, 8);
    orig = 256'd0;
    for (int i = 0; i <= 2000; i++) begin
      @(negedge clk);
      checks++;
      if (b_out_valid !== 1'b1 || b_data_o !== expv) $display("FAIL nb8_blk%0d got=%h exp=%h", i, b_data_o, expv);
      else passed++;
      if (i == 0) begin
        x = b_data_o;
        checks++;
        if (x[255:224] !== 32'h00050e13) $display("FAIL nb8_col0 got=%h exp=00050e13", x[255:224]);
        else passed++;
      end
      cm++;
      if (i == 2000) begin
        b_in_valid = 1'b0;
      end else if (i % 2 == 0) begin
        orig = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        b_inv = 1'b0; b_data_i = orig; expv = ref_sr(orig, 1'b0, 8);
      end else begin
        b_inv = 1'b1; b_data_i = ref_sr(orig, 1'b0, 8); expv = orig;
      end
    end
    @(negedge clk);
    checks++;
    if (b_out_valid !== 1'b0 || b_cnt !== cm[15:0]) $display("FAIL nb8_cnt got=%b %0d exp=0 %0d", b_out_valid, b_cnt, cm);
    else passed++;
  endtask

  task automatic test_backpressure();
    bit acc;
    logic [127:0] blk[3];
    step_a(1'b1, 1'b0, 1'b0, 128'd0, 1'b0, acc);
    for (int i = 0; i < 3; i++) blk[i] = rand128();
    step_a(1'b0, 1'b1, 1'b0, blk[0], 1'b0, acc);
    step_a(1'b0, 1'b1, 1'b1, blk[1], 1'b0, acc);
    for (int i = 0; i < 3; i++) begin
      step_a(1'b0, 1'b1, 1'b0, blk[2], 1'b0, acc);
      checks++;
      if (a_in_ready !== 1'b0 || acc) $display("FAIL t4_in_ready got=%b exp=0", a_in_ready);
      else passed++;
    end
    acc = 1'b0;
    for (int i = 0; i < 10 && !acc; i++) step_a(1'b0, 1'b1, 1'b0, blk[2], 1'b1, acc);
    idle_a(3);
    checks++;
    if (a_cnt !== 4'd3) $display("FAIL t4_cnt got=%0d exp=3", a_cnt);
    else passed++;
  endtask

  task automatic test_random_stream();
    bit acc, v, rdy, pinv;
    logic [127:0] pdat;
    int cyc;
    pdat = rand128(); pinv = 1'($urandom_range(0, 1));
    drained = 0;
    cyc = 0;
    while (drained < 10000 && cyc < 60000) begin
      v = ($urandom_range(0, 3) != 0);
      rdy = ($urandom_range(0, 3) != 0);
      step_a(1'b0, v, pinv, pdat, rdy, acc);
      if (acc) begin
        pdat = rand128(); pinv = 1'($urandom_range(0, 1));
      end
      cyc++;
    end
    checks++;
    if (drained < 10000) $display("FAIL t5_budget got=%0d exp=10000", drained);
    else passed++;
    idle_a(3);
  endtask

  task automatic test_wrap_flush_reset();
    bit acc;
    step_a(1'b1, 1'b0, 1'b0, 128'd0, 1'b1, acc);
    for (int i = 0; i < 17; i++) step_a(1'b0, 1'b1, 1'b0, rand128(), 1'b1, acc);
    idle_a(2);
    checks++;
    if (a_cnt !== 4'd1) $display("FAIL t6_wrap got=%0d exp=1", a_cnt);
    else passed++;
    step_a(1'b0, 1'b1, 1'b0, rand128(), 1'b0, acc);
    step_a(1'b0, 1'b1, 1'b1, rand128(), 1'b0, acc);
    step_a(1'b1, 1'b1, 1'b0, rand128(), 1'b1, acc);
    @(posedge clk); #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_cnt !== 4'd0)
      $display("FAIL t6_flush got=%b%b %0d exp=01 0", a_out_valid, a_in_ready, a_cnt);
    else passed++;
    for (int i = 0; i < 5; i++) step_a(1'b0, 1'b1, 1'b0, rand128(), i[0], acc);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_data_o !== 128'd0 || a_cnt !== 4'd0)
      $display("FAIL t6_reset got=%b%b %h %0d exp=01 0 0", a_out_valid, a_in_ready, a_data_o, a_cnt);
    else passed++;
    @(negedge clk);
    a_in_valid = 1'b0; a_out_ready = 1'b1; a_flush = 1'b0;
    sb_q.delete(); cnt_m = 0; stall_m = 1'b0;
    rst_n = 1'b1;
    idle_a(2);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    test_reset();
    test_fwd_vector();
    test_inv_alternate();
    test_nb8();
    test_backpressure();
    test_random_stream();
    test_wrap_flush_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
